// File: rtl/frame_bram_pkg.sv
// Shared definitions for the frame buffer arbiter and the blur/edge engines.
package frame_bram_pkg;

   localparam int ADDR_W_DEF = 17;  // 320x240 pixel words
   localparam int DATA_W_DEF = 12;  // RGB444

   // Requester ID carried alongside each read through the return pipeline.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_DISP = 2'd1,
      SRC_BLUR = 2'd2,
      SRC_EDGE = 2'd3
   } src_e;

endpackage

// File: rtl/frame_bram_arbiter.sv
// Three-way arbiter in front of a single-port frame BRAM: display reads,
// blur engine and edge engine. Display has priority but is bounded by a burst
// counter so the engines are never starved; the engines share round-robin.
module frame_bram_arbiter
   import frame_bram_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int DISP_BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              blur_req,
   input  logic              blur_we,
   input  logic [ADDR_W-1:0] blur_addr,
   input  logic [DATA_W-1:0] blur_wdata,
   input  logic              edge_req,
   input  logic              edge_we,
   input  logic [ADDR_W-1:0] edge_addr,
   input  logic [DATA_W-1:0] edge_wdata,
   output logic              disp_gnt,
   output logic              blur_gnt,
   output logic              edge_gnt,
   output logic              disp_rvalid,
   output logic              blur_rvalid,
   output logic              edge_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_we,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata
);

   localparam int              CNT_W   = $clog2(DISP_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DISP_BURST_MAX);

   logic [CNT_W-1:0]  burst_q, burst_d;
   src_e              last_q, last_d;
   src_e              tag1_q, tag1_d;
   src_e              tag2_q;
   src_e              win;
   logic              eng_req;
   logic              eng_win;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   assign eng_req = blur_req | edge_req;
   assign eng_win = (win == SRC_BLUR) || (win == SRC_EDGE);

   // Pick the winner for this cycle; nothing is granted while reset is low.
   always_comb begin
      win = SRC_NONE;
      if (reset_n) begin
         if (disp_req && !(eng_req && (burst_q == CNT_MAX))) begin
            win = SRC_DISP;
         end else if (blur_req && edge_req) begin
            win = (last_q == SRC_BLUR) ? SRC_EDGE : SRC_BLUR;
         end else if (blur_req) begin
            win = SRC_BLUR;
         end else if (edge_req) begin
            win = SRC_EDGE;
         end
      end
   end

   assign disp_gnt = (win == SRC_DISP);
   assign blur_gnt = (win == SRC_BLUR);
   assign edge_gnt = (win == SRC_EDGE);

   // Next-state for burst counter, round-robin pointer, BRAM drive and read tag.
   always_comb begin
      burst_d = burst_q;
      last_d  = last_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      tag1_d  = SRC_NONE;

      // Counter only measures display grants made while an engine is waiting.
      if (!eng_req || eng_win) begin
         burst_d = '0;
      end else if ((win == SRC_DISP) && (burst_q != CNT_MAX)) begin
         burst_d = burst_q + CNT_W'(1);
      end

      if (eng_win) begin
         last_d = win;
      end

      case (win)
         SRC_DISP: begin
            addr_d = disp_addr;
            tag1_d = SRC_DISP;
         end
         SRC_BLUR: begin
            addr_d  = blur_addr;
            we_d    = blur_we;
            wdata_d = blur_wdata;
            tag1_d  = blur_we ? SRC_NONE : SRC_BLUR;
         end
         SRC_EDGE: begin
            addr_d  = edge_addr;
            we_d    = edge_we;
            wdata_d = edge_wdata;
            tag1_d  = edge_we ? SRC_NONE : SRC_EDGE;
         end
         default: ;
      endcase
   end

   // State registers; reset drops any reads still in the tag pipeline.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         burst_q <= '0;
         last_q  <= SRC_EDGE;
         tag1_q  <= SRC_NONE;
         tag2_q  <= SRC_NONE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         burst_q <= burst_d;
         last_q  <= last_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag1_q;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign bram_addr   = addr_q;
   assign bram_we     = we_q;
   assign bram_wdata  = wdata_q;
   assign rdata       = bram_rdata;
   assign disp_rvalid = (tag2_q == SRC_DISP);
   assign blur_rvalid = (tag2_q == SRC_BLUR);
   assign edge_rvalid = (tag2_q == SRC_EDGE);

endmodule

// File: tb/tb_frame_bram_arbiter.sv
module tb_frame_bram_arbiter;
   import frame_bram_pkg::*;

   localparam int AW = 17;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          disp_req, blur_req, blur_we, edge_req, edge_we;
   logic [AW-1:0] disp_addr, blur_addr, edge_addr;
   logic [DW-1:0] blur_wdata, edge_wdata;
   logic          disp_gnt, blur_gnt, edge_gnt;
   logic          disp_rvalid, blur_rvalid, edge_rvalid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] bram_addr;
   logic          bram_we;
   logic [DW-1:0] bram_wdata;
   logic [DW-1:0] bram_rdata;

   int compared   = 0;
   int mismatched = 0;
   int cyc_cnt    = 0;
   bit mon_en     = 1'b0;

   typedef struct {
      int        ecyc;
      src_e      id;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   // BRAM and bench shadow both store a delta against a fixed background pattern.
   bit [DW-1:0] mem_delta [0:1023];
   bit [DW-1:0] sh_delta  [0:1023];

   frame_bram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .blur_req(blur_req), .blur_we(blur_we), .blur_addr(blur_addr), .blur_wdata(blur_wdata),
      .edge_req(edge_req), .edge_we(edge_we), .edge_addr(edge_addr), .edge_wdata(edge_wdata),
      .disp_gnt(disp_gnt), .blur_gnt(blur_gnt), .edge_gnt(edge_gnt),
      .disp_rvalid(disp_rvalid), .blur_rvalid(blur_rvalid), .edge_rvalid(edge_rvalid),
      .rdata(rdata),
      .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
      .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [DW-1:0] bg_word(input logic [AW-1:0] a);
      return DW'(32'(a) * 13 + 7);
   endfunction

   always @(posedge clk) begin
      if (bram_we) mem_delta[bram_addr[9:0]] <= bram_wdata ^ bg_word(bram_addr);
      bram_rdata <= mem_delta[bram_addr[9:0]] ^ bg_word(bram_addr);
   end

   function automatic logic [2:0] onehot(input src_e id);
      case (id)
         SRC_DISP: return 3'b100;
         SRC_BLUR: return 3'b010;
         SRC_EDGE: return 3'b001;
         default:  return 3'b000;
      endcase
   endfunction

   // Monitor: every rvalid must match the oldest expected read, in the right cycle.
   always @(negedge clk) begin : monitor
      logic [2:0] rv;
      exp_t       e;
      if (mon_en) begin
         rv = {disp_rvalid, blur_rvalid, edge_rvalid};
         while (exp_q.size() > 0 && exp_q[0].ecyc < cyc_cnt) begin
            compared++;
            mismatched++;
            $display("FAIL rvalid_missing cycle %0d: got no rvalid, required id %0d data %h in cycle %0d",
                     cyc_cnt, exp_q[0].id, exp_q[0].data, exp_q[0].ecyc);
            void'(exp_q.pop_front());
         end
         if (rv != 3'b000) begin
            compared++;
            if (exp_q.size() == 0 || exp_q[0].ecyc != cyc_cnt) begin
               mismatched++;
               $display("FAIL rvalid_unexpected cycle %0d: got rvalid %b, required none", cyc_cnt, rv);
            end else begin
               e = exp_q.pop_front();
               if (rv !== onehot(e.id) || rdata !== e.data) begin
                  mismatched++;
                  $display("FAIL read_return cycle %0d: got rvalid %b rdata %h, required rvalid %b rdata %h",
                           cyc_cnt, rv, rdata, onehot(e.id), e.data);
               end
            end
         end
      end
   end

   task automatic push_read(input src_e id, input logic [AW-1:0] a);
      exp_t e;
      e.ecyc = cyc_cnt + 2;
      e.id   = id;
      e.data = sh_delta[a[9:0]] ^ bg_word(a);
      exp_q.push_back(e);
   endtask

   task automatic shadow_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      sh_delta[a[9:0]] = d ^ bg_word(a);
   endtask

   // One cycle: drive requests, check the grant vector, record expected effects.
   task automatic step(input logic dr, input logic [AW-1:0] da,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input logic [2:0] eg, input string nm);
      disp_req = dr; disp_addr = da;
      blur_req = br; blur_we = bw; blur_addr = ba; blur_wdata = bd;
      edge_req = er; edge_we = ew; edge_addr = ea; edge_wdata = ed;
      @(negedge clk);
      compared++;
      if ({disp_gnt, blur_gnt, edge_gnt} !== eg) begin
         mismatched++;
         $display("FAIL %s cycle %0d: got gnt %b, required %b", nm, cyc_cnt,
                  {disp_gnt, blur_gnt, edge_gnt}, eg);
      end
      case (eg)
         3'b100: push_read(SRC_DISP, da);
         3'b010: if (bw) shadow_wr(ba, bd); else push_read(SRC_BLUR, ba);
         3'b001: if (ew) shadow_wr(ea, ed); else push_read(SRC_EDGE, ea);
         default: ;
      endcase
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         disp_req = 1'b0; blur_req = 1'b0; edge_req = 1'b0;
         blur_we = 1'b0; edge_we = 1'b0;
         @(negedge clk);
         compared++;
         if ({disp_gnt, blur_gnt, edge_gnt} !== 3'b000) begin
            mismatched++;
            $display("FAIL %s_gnt cycle %0d: got gnt %b, required 000", nm, cyc_cnt,
                     {disp_gnt, blur_gnt, edge_gnt});
         end
         if (k >= 1) begin
            compared++;
            if (bram_we !== 1'b0) begin
               mismatched++;
               $display("FAIL %s_we cycle %0d: got bram_we %b, required 0", nm, cyc_cnt, bram_we);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   // Hold reset for n cycles with whatever requests are currently driven.
   task automatic do_reset(input int n, input bit chk_regs);
      reset_n = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].ecyc > cyc_cnt) void'(exp_q.pop_back());
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         compared++;
         if ({disp_gnt, blur_gnt, edge_gnt} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_gnt cycle %0d: got gnt %b, required 000", cyc_cnt,
                     {disp_gnt, blur_gnt, edge_gnt});
         end
         if (chk_regs && k >= 1) begin
            compared++;
            if (bram_we !== 1'b0 || bram_addr !== '0 || bram_wdata !== '0) begin
               mismatched++;
               $display("FAIL reset_regs cycle %0d: got we %b addr %h wdata %h, required 0 0 0",
                        cyc_cnt, bram_we, bram_addr, bram_wdata);
            end
         end
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      disp_req = 1'b1; disp_addr = 17'd1;
      blur_req = 1'b1; blur_we = 1'b1; blur_addr = 17'd2; blur_wdata = 12'h111;
      edge_req = 1'b1; edge_we = 1'b0; edge_addr = 17'd3; edge_wdata = 12'h222;
      @(posedge clk); #1;
      do_reset(3, 1'b1);
      mon_en = 1'b1;

      idle(10, "idle");

      // Display reads of words 5 and 6 back to back.
      step(1, 17'd5, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, "disp5");
      step(1, 17'd6, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, "disp6");
      idle(3, "drain1");

      // Both engines reading: blur first after reset, then alternate.
      for (int i = 0; i < 6; i++)
         step(0, 0, 1, 0, 17'd20, 0, 1, 0, 17'd30, 0, (i % 2 == 0) ? 3'b010 : 3'b001, "rr");
      idle(3, "drain2");

      // Display against a waiting blur: 8 display grants then one blur grant.
      for (int i = 0; i < 27; i++)
         step(1, 17'd40, 1, 0, 17'd50, 0, 0, 0, 0, 0, (i % 9 == 8) ? 3'b010 : 3'b100, "burst");
      idle(3, "drain3");

      // Write then immediate read of the same word.
      step(0, 0, 0, 0, 0, 0, 1, 1, 17'd100, 12'hABC, 3'b001, "edge_wr");
      step(0, 0, 1, 0, 17'd100, 0, 0, 0, 0, 0, 3'b010, "blur_rd");
      // Last engine was blur, so edge wins the tie.
      step(0, 0, 1, 1, 17'd200, 12'h123, 1, 0, 17'd100, 0, 3'b001, "tie_edge");
      step(0, 0, 1, 1, 17'd200, 12'h123, 0, 0, 0, 0, 3'b010, "blur_wr");
      step(1, 17'd200, 0, 0, 0, 0, 1, 0, 17'd200, 0, 3'b100, "disp_raw");
      step(0, 0, 0, 0, 0, 0, 1, 0, 17'd200, 0, 3'b001, "edge_raw");
      idle(3, "drain4");

      // Reset right after a blur read grant: that read must vanish.
      step(0, 0, 1, 0, 17'd300, 0, 0, 0, 0, 0, 3'b010, "blur_pre_rst");
      blur_req = 1'b0;
      do_reset(2, 1'b1);
      step(0, 0, 1, 0, 17'd20, 0, 1, 0, 17'd30, 0, 3'b010, "rr_after_rst0");
      step(0, 0, 1, 0, 17'd20, 0, 1, 0, 17'd30, 0, 3'b001, "rr_after_rst1");
      idle(3, "drain5");

      // Partially filled burst counter must clear on reset.
      for (int i = 0; i < 4; i++)
         step(1, 17'd40, 1, 0, 17'd50, 0, 0, 0, 0, 0, 3'b100, "burst_pre_rst");
      do_reset(1, 1'b0);
      for (int i = 0; i < 9; i++)
         step(1, 17'd41, 1, 0, 17'd51, 0, 0, 0, 0, 0, (i == 8) ? 3'b010 : 3'b100, "burst_post_rst");

      idle(5, "final");
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL outstanding_reads: got %0d pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/frame_bram_arbiter.md
FRAME_BRAM_ARBITER -- requirements
Module: frame_bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, BRAM word address width (320x240 frame).
REQ-002 Parameter DATA_W, default 12, BRAM word width (RGB444 pixel).
REQ-003 Parameter DISP_BURST_MAX, default 8, maximum consecutive display grants while an engine waits.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 disp_req  in  1  display read request; disp_addr  in  ADDR_W  display read address.
REQ-007 blur_req, blur_we  in  1 each  blur engine request and write enable; blur_addr  in  ADDR_W; blur_wdata  in  DATA_W.
REQ-008 edge_req, edge_we  in  1 each  edge-detection engine request and write enable; edge_addr  in  ADDR_W; edge_wdata  in  DATA_W.
REQ-009 disp_gnt, blur_gnt, edge_gnt  out  1 each  request accepted this cycle.
REQ-010 disp_rvalid, blur_rvalid, edge_rvalid  out  1 each  rdata belongs to that requester this cycle.
REQ-011 rdata  out  DATA_W  shared read-return data.
REQ-012 bram_addr  out  ADDR_W; bram_we  out  1; bram_wdata  out  DATA_W  registered single-port BRAM drive.
REQ-013 bram_rdata  in  DATA_W  BRAM output, valid one cycle after bram_addr is presented.

Function
REQ-014 Arbiter SHALL assert at most one gnt per cycle; gnt is combinational from the current req inputs and arbiter state.
REQ-015 A requester SHALL hold req, we, addr and wdata stable until its gnt is high; each gnt-high cycle accepts exactly one access.
REQ-016 Priority: display first, unless the burst counter equals DISP_BURST_MAX and an engine requests; in that case the engine SHALL win.
REQ-017 Burst counter SHALL increment on each display grant made while blur_req or edge_req is high, and SHALL clear on any engine grant or in any cycle with no engine request; it saturates at DISP_BURST_MAX.
REQ-018 Between blur and edge, round-robin: when both request, grant the one not granted last; last_engine updates only on an engine grant.
REQ-019 On a grant, bram_addr/we/wdata SHALL register the winner's signals at the next edge; with no grant, bram_we SHALL register 0 and bram_addr hold its value.
REQ-020 Display accesses are reads only; bram_we SHALL be 0 for a display grant.
REQ-021 Read latency SHALL be exactly 2 cycles: a read granted in cycle N gives rdata = bram_rdata and exactly one rvalid high in cycle N+2.
REQ-022 A 2-stage requester-tag pipeline SHALL carry the source ID of each granted read; write grants carry NONE.
REQ-023 Back-to-back grants to any mix of requesters SHALL be sustained at one access per cycle with no bubbles.
REQ-024 A write followed in the next cycle by a read of the same address SHALL return the new data (BRAM read-after-write ordering is preserved).
REQ-025 With no requests, all gnt and rvalid SHALL be 0.

Reset
REQ-026 While reset_n=0 at an edge: tag pipeline := NONE, burst counter := 0, last_engine := EDGE (blur wins the first tie), bram_we := 0, bram_addr := 0, bram_wdata := 0.
REQ-027 All gnt SHALL be 0 while reset_n=0; all rvalid SHALL be 0 in the cycle after reset is sampled.
REQ-028 Reads in flight when reset is asserted SHALL be dropped; no rvalid is produced for them.

Structure
REQ-029 Package frame_bram_pkg SHALL hold the requester ID encoding (NONE=0, DISP=1, BLUR=2, EDGE=3) and the default ADDR_W/DATA_W constants, shared with the blur and edge engines.
REQ-030 Single module; no sub-module is required.

Verification
REQ-031 disp_req only, addr 5, then addr 6 on consecutive cycles, BRAM model -> disp_gnt high both cycles, disp_rvalid in cycles +2 and +3 with data of words 5 and 6.
REQ-032 blur_req and edge_req held high, reads -> grants alternate BLUR, EDGE, BLUR, ...; BLUR is granted first after reset.
REQ-033 disp_req and blur_req held high -> 8 disp grants, then 1 blur grant, then repeating; blur is never starved.
REQ-034 edge write addr 100 data 0xABC, then blur read addr 100 next cycle -> blur_rvalid with rdata 0xABC two cycles after the read grant.
REQ-035 reset_n pulled low 1 cycle after a blur read grant -> no blur_rvalid afterwards; after release, counters and round-robin state are at their reset values.
REQ-036 No requests for 10 cycles -> all gnt, rvalid and bram_we are 0.
